// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin scheduler sharing one sequential 12/6 restoring
// divider between N_REQ requesters.
// Optional feature macro: DIVIDER_ARBITER_ZERO_CHECK_EN. When it is defined,
// zero divisors are answered locally and the divider is not launched.
module divider_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DRAIN_CYCLES = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [12*N_REQ-1:0]   req_aq,
  input  logic [6*N_REQ-1:0]    req_div,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [5:0]            rsp_quotient,
  output logic [5:0]            rsp_remainder,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  div_start,
  output logic [11:0]           div_aq,
  output logic [5:0]            div_divisor,
  input  logic                  div_ready,
  input  logic [5:0]            div_quotient,
  input  logic [5:0]            div_remainder
);

  localparam int unsigned AQ_W  = 12;
  localparam int unsigned DV_W  = 6;
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [N_REQ-1:0]   gnt_d, rsp_valid_d;
  logic [5:0]         q_d, r_d;
  logic               err_d, busy_d, start_d;
  logic [AQ_W-1:0]    aq_d;
  logic [DV_W-1:0]    dv_d;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
  logic               zero_pend, zero_d;
`endif

  logic               win_found;
  logic [IDX_W-1:0]   win_idx, cand;
  logic [AQ_W-1:0]    sel_aq;
  logic [DV_W-1:0]    sel_dv;
  logic [N_REQ-1:0]   sel_oh;

  // Round-robin pick: first set request scanning upward from the pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Operand mux and one-hot grant for the winning requester
  always_comb begin
    sel_aq = '0;
    sel_dv = '0;
    sel_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_aq    = req_aq[AQ_W*i +: AQ_W];
        sel_dv    = req_div[DV_W*i +: DV_W];
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ptr_d       = ptr;
    gnt_d       = gnt;
    rsp_valid_d = '0;
    q_d         = rsp_quotient;
    r_d         = rsp_remainder;
    err_d       = rsp_err;
    start_d     = 1'b0;
    aq_d        = div_aq;
    dv_d        = div_divisor;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
    zero_d      = zero_pend;
`endif
    unique case (state)
      // Let a divider run left over from before reset drain out
      ST_SETTLE: begin
        if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt + 1'b1);
        end
      end
      ST_IDLE: begin
        if (win_found) begin
          aq_d    = sel_aq;
          dv_d    = sel_dv;
          gnt_d   = sel_oh;
          ptr_d   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(win_idx + 1'b1);
          state_d = ST_LAUNCH;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
          if (sel_dv == '0) begin
            state_d = ST_RESP;
            zero_d  = 1'b1;
          end
`endif
        end
      end
      ST_LAUNCH: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_ready) begin
          q_d         = div_quotient;
          r_d         = div_remainder;
          err_d       = 1'b0;
          rsp_valid_d = gnt;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
        if (zero_pend) begin
          rsp_valid_d = gnt;
          q_d         = 6'h3F;
          r_d         = div_aq[11:6];
          err_d       = 1'b1;
          zero_d      = 1'b0;
        end else
`endif
        begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_SETTLE;
      cnt           <= '0;
      ptr           <= '0;
      gnt           <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      div_start     <= 1'b0;
      div_aq        <= '0;
      div_divisor   <= '0;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
      zero_pend     <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ptr           <= ptr_d;
      gnt           <= gnt_d;
      rsp_valid     <= rsp_valid_d;
      rsp_quotient  <= q_d;
      rsp_remainder <= r_d;
      rsp_err       <= err_d;
      busy          <= busy_d;
      div_start     <= start_d;
      div_aq        <= aq_d;
      div_divisor   <= dv_d;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
      zero_pend     <= zero_d;
`endif
    end
  end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin scheduler that shares one sequential 12/6-bit restoring divider between `N_REQ` requesters. It captures a winning requester's operands and drives the divider's `start`/`aq`/`div` inputs with the required pulse. It then waits for the divider's `ready` and returns quotient and remainder to the winner with a one-cycle response pulse. It sits between the client blocks and the single divider instance in the arithmetic subsystem.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `DRAIN_CYCLES`, 48, post-reset quiet cycles before first launch; must be at least the divider's worst-case run length.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: per-requester level request, held until its `rsp_valid`.
- `req_aq` in `12*N_REQ`: dividends, requester i at bits [12i+11:12i].
- `req_div` in `6*N_REQ`: divisors, requester i at bits [6i+5:6i].
- `gnt` out `N_REQ`: one-hot grant, high from capture through response cycle.
- `rsp_valid` out `N_REQ`: one-cycle pulse to the served requester.
- `rsp_quotient` out 6: shared result, valid when any `rsp_valid` is high.
- `rsp_remainder` out 6: shared result, valid with `rsp_valid`.
- `rsp_err` out 1: divide-by-zero flag, valid with `rsp_valid`.
- `busy` out 1: high in every state except IDLE.
- `div_start` out 1: divider start, exactly one cycle per launch.
- `div_aq` out 12: captured dividend, stable from capture until the response.
- `div_divisor` out 6: captured divisor, stable from capture until the response.
- `div_ready` in 1: divider completion pulse.
- `div_quotient` in 6: divider quotient, sampled on `div_ready`.
- `div_remainder` in 6: divider remainder, sampled on `div_ready`.

## Operation
- **States:** SETTLE, IDLE, LAUNCH, WAIT, RESP.
- **Reset:** all outputs 0, state SETTLE, drain counter 0, round-robin pointer 0, operand and result registers 0.
- **Why SETTLE exists:** the divider has no reset, so an operation in flight at reset must be allowed to finish.
- **SETTLE:** count `DRAIN_CYCLES` cycles with `div_start`=0, then go to IDLE. Any `div_ready` seen here is ignored.
- **IDLE:** if any `req` is high, pick the first set bit scanning upward from the pointer, wrapping at `N_REQ-1`.
  - Capture that requester's `req_aq`/`req_div` into `div_aq`/`div_divisor`.
  - Set `gnt`[i] and move the pointer to (i+1) mod `N_REQ`.
  - Go to LAUNCH.
- **LAUNCH:** `div_start`=1 for exactly this cycle, then WAIT. A single-cycle start lets the divider pass its init state and load operands two cycles later.
- **WAIT:** hold until `div_ready`=1. On that edge, register `div_quotient`/`div_remainder`, set `rsp_err`=0, go to RESP.
- **RESP:** `rsp_valid`[i]=1 for one cycle; `rsp_*` hold the registered result. Next edge: clear `gnt` and go to IDLE.
- **Result hold:** `rsp_*` keep their value until the next response.
- **Dropped request:** if `req`[i] falls after grant, the transaction still completes and the response is still issued.
- **New requests during service:** sampled only in IDLE. A request present in the RESP cycle competes at the next IDLE cycle.
- **Spurious `div_ready`:** ignored in IDLE, LAUNCH and RESP.
- **Reset mid-operation:** abort immediately to SETTLE with outputs 0. No response is issued for the aborted transaction.
- **Zero requests:** stay in IDLE, `busy`=0.

## Timing
- Grant-to-start latency: `gnt` rises at edge E, and `div_start` is high during cycle E+1.
- Response latency: `rsp_valid` is high the cycle after the `div_ready` cycle.
- End-to-end with the standard divider: 4 + 6·k cycles + ~7 overhead (k = per-iteration cost, 4..7).
- Back-to-back service: the RESP, IDLE and capture steps take one cycle each, so there are no idle gaps when requests are pending.
- Fairness: a continuously asserted request waits at most `N_REQ`-1 other transactions.

## Configuration
- Macro: `DIVIDER_ARBITER_ZERO_CHECK_EN`.
- **Defined:** in IDLE, if the winner's divisor is 0, capture as usual but go directly to RESP.
  - No `div_start` is issued.
  - `rsp_quotient`=6'h3F, `rsp_remainder`=dividend[11:6], `rsp_err`=1.
  - Response comes 1 cycle after the grant.
- **Undefined:** zero divisors are launched like any other, and `rsp_err` is tied 0.

## Test plan
- **Single request:** reset, wait `DRAIN_CYCLES`, `req`[0] with aq=12'd100, div=6'd7.
  - `div_start` is a single pulse one cycle after `gnt`[0].
  - `rsp_valid`[0] fires once, with quotient=14, remainder=2.
- **All requesters at once:** `req`=4'hF held. Grants come in the order 0,1,2,3,0, each as a one-cycle-spaced transaction. Use aq=12'd63, div=6'd9 for all; every response is q=7, r=0.
- **Drop after grant:** deassert `req`[2] one cycle after `gnt`[2]. `rsp_valid`[2] still pulses, and the next grant goes to requester 3.
- **Reset during WAIT:** pull `rst_n` low. All outputs go to 0 immediately, with no `rsp_valid`. After release, `div_start` stays 0 for exactly `DRAIN_CYCLES`, then the pending request is served correctly.
- **Zero divisor, macro defined:** div=0, aq=12'hA80. One cycle after `gnt`: `rsp_err`=1, q=6'h3F, r=6'h2A, and `div_start` is never asserted.
- **Zero divisor, macro undefined:** same stimulus. The divider is launched and `rsp_err`=0.
